// File: rtl/ahfp_addsub_pipe.sv
// rtl/ahfp_addsub_pipe.sv - five-stage IEEE-754-format floating-point adder/subtractor
module ahfp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic                       op,
    input  logic [EXP_W+MAN_W:0]       dataa,
    input  logic [EXP_W+MAN_W:0]       datab,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    output logic [EXP_W+MAN_W:0]       result,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    // working mantissa: hidden bit, MAN_W fraction bits, guard, round, sticky
    localparam int AW = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // ---------------- S1: unpack, classify, order by magnitude ----------------
    logic               sa, sb, za, zb, inf_a, inf_b, nan_a, nan_b, swap;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic [MAN_W:0]     ma, mb;

    assign sa    = dataa[W-1];
    assign sb    = datab[W-1] ^ op;
    assign ea    = dataa[W-2:MAN_W];
    assign eb    = datab[W-2:MAN_W];
    assign fa    = dataa[MAN_W-1:0];
    assign fb    = datab[MAN_W-1:0];
    assign za    = (ea == '0);
    assign zb    = (eb == '0);
    assign inf_a = (ea == EXP_ONES) && (fa == '0);
    assign inf_b = (eb == EXP_ONES) && (fb == '0);
    assign nan_a = (ea == EXP_ONES) && (fa != '0);
    assign nan_b = (eb == EXP_ONES) && (fb != '0);
    // denormals collapse to zero, so their fraction never reaches the datapath
    assign ma    = za ? '0 : {1'b1, fa};
    assign mb    = zb ? '0 : {1'b1, fb};
    assign swap  = {eb, mb[MAN_W-1:0]} > {ea, ma[MAN_W-1:0]};

    logic               s1_valid, s1_nan, s1_inf, s1_sign, s1_sub;
    logic [TAG_W-1:0]   s1_tag;
    logic [EXP_W-1:0]   s1_bexp, s1_sexp;
    logic [MAN_W:0]     s1_bman, s1_sman;

    // S1 register: larger-magnitude operand goes to the "big" slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sub   <= 1'b0;
            s1_bexp  <= '0;
            s1_sexp  <= '0;
            s1_bman  <= '0;
            s1_sman  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
            s1_nan   <= nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
            s1_inf   <= inf_a | inf_b;
            s1_sign  <= swap ? sb : sa;
            s1_sub   <= sa ^ sb;
            s1_bexp  <= swap ? eb : ea;
            s1_sexp  <= swap ? ea : eb;
            s1_bman  <= swap ? mb : ma;
            s1_sman  <= swap ? ma : mb;
        end
    end

    // ---------------- S2: align the smaller operand ----------------
    logic [EXP_W-1:0]   diff;
    int                 sh;
    logic [2*AW-1:0]    ext;
    logic [AW-1:0]      aligned;

    // shift saturates once the small operand lies wholly in the sticky slot
    always_comb begin
        diff    = s1_bexp - s1_sexp;
        sh      = (int'(diff) > MAN_W + 3) ? MAN_W + 3 : int'(diff);
        ext     = {s1_sman, 3'b000, {AW{1'b0}}} >> sh;
        aligned = ext[2*AW-1:AW] | {{(AW-1){1'b0}}, |ext[AW-1:0]};
    end

    logic               s2_valid, s2_nan, s2_inf, s2_sign, s2_sub;
    logic [TAG_W-1:0]   s2_tag;
    logic [EXP_W-1:0]   s2_exp;
    logic [AW-1:0]      s2_big, s2_small;

    // S2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            s2_nan   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_sign  <= 1'b0;
            s2_sub   <= 1'b0;
            s2_exp   <= '0;
            s2_big   <= '0;
            s2_small <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_sign  <= s1_sign;
            s2_sub   <= s1_sub;
            s2_exp   <= s1_bexp;
            s2_big   <= {s1_bman, 3'b000};
            s2_small <= aligned;
        end
    end

    // ---------------- S3: mantissa add/subtract ----------------
    logic [AW:0]        sum;
    logic               sign3;

    // big >= small, so the difference never goes negative; exact cancellation is +0
    always_comb begin
        sum   = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                       : ({1'b0, s2_big} + {1'b0, s2_small});
        sign3 = (s2_sub && (sum == '0)) ? 1'b0 : s2_sign;
    end

    logic               s3_valid, s3_nan, s3_inf, s3_sign;
    logic [TAG_W-1:0]   s3_tag;
    logic [EXP_W-1:0]   s3_exp;
    logic [AW:0]        s3_sum;

    // S3 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_tag   <= '0;
            s3_nan   <= 1'b0;
            s3_inf   <= 1'b0;
            s3_sign  <= 1'b0;
            s3_exp   <= '0;
            s3_sum   <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_tag   <= s2_tag;
            s3_nan   <= s2_nan;
            s3_inf   <= s2_inf;
            s3_sign  <= sign3;
            s3_exp   <= s2_exp;
            s3_sum   <= sum;
        end
    end

    // ---------------- S4: normalise ----------------
    int                 lz;
    int                 e4;
    logic               found;
    logic [AW-1:0]      man4;
    logic               zero4;

    // carry-out shifts right one place; otherwise shift out leading zeros
    always_comb begin
        lz    = 0;
        found = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
            if (!found) begin
                if (s3_sum[i]) found = 1'b1;
                else           lz = lz + 1;
            end
        end
        e4 = int'(s3_exp);
        if (s3_sum[AW]) begin
            man4 = s3_sum[AW:1] | {{(AW-1){1'b0}}, s3_sum[0]};
            e4   = e4 + 1;
        end else begin
            man4 = s3_sum[AW-1:0] << lz;
            e4   = e4 - lz;
        end
        zero4 = (s3_sum == '0) || (e4 < 1);
    end

    logic               s4_valid, s4_nan, s4_inf, s4_sign, s4_zero;
    logic [TAG_W-1:0]   s4_tag;
    logic [EXP_W:0]     s4_exp;
    logic [AW-1:0]      s4_man;

    // S4 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_valid <= 1'b0;
            s4_tag   <= '0;
            s4_nan   <= 1'b0;
            s4_inf   <= 1'b0;
            s4_sign  <= 1'b0;
            s4_zero  <= 1'b0;
            s4_exp   <= '0;
            s4_man   <= '0;
        end else if (en) begin
            s4_valid <= s3_valid;
            s4_tag   <= s3_tag;
            s4_nan   <= s3_nan;
            s4_inf   <= s3_inf;
            s4_sign  <= s3_sign;
            s4_zero  <= zero4;
            s4_exp   <= (EXP_W+1)'(e4);
            s4_man   <= man4;
        end
    end

    // ---------------- S5: round to nearest even, pack ----------------
    logic [MAN_W:0]     mant5;
    logic [MAN_W+1:0]   mr;
    logic [MAN_W-1:0]   frac5;
    logic               inc;
    int                 e5;
    logic [W-1:0]       packed5;

    // a rounding carry leaves the fraction at zero and bumps the exponent
    always_comb begin
        mant5 = s4_man[AW-1:3];
        inc   = s4_man[2] & (s4_man[1] | s4_man[0] | mant5[0]);
        mr    = {1'b0, mant5} + {{(MAN_W+1){1'b0}}, inc};
        e5    = int'(s4_exp) + (mr[MAN_W+1] ? 1 : 0);
        frac5 = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        if (s4_nan)
            packed5 = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        else if (s4_inf)
            packed5 = {s4_sign, EXP_ONES, {MAN_W{1'b0}}};
        else if (s4_zero)
            packed5 = {s4_sign, {(W-1){1'b0}}};
        else if (e5 >= (2**EXP_W) - 1)
            packed5 = {s4_sign, EXP_ONES, {MAN_W{1'b0}}};
        else
            packed5 = {s4_sign, EXP_W'(e5), frac5};
    end

    // output register: result, tag and valid leave together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= s4_valid;
            result    <= packed5;
            out_tag   <= s4_tag;
        end
    end

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// tb/tb_ahfp_addsub_pipe.sv - directed self-checking bench for ahfp_addsub_pipe
module tb_ahfp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  out_tag;

    int total = 0;
    int passed = 0;

    logic [31:0] q_res[$];
    logic [3:0]  q_tag[$];

    logic [31:0] st_a   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] st_exp [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    ahfp_addsub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .op        (op),
        .dataa     (dataa),
        .datab     (datab),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .result    (result),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    endtask

    // one clock; a result is collected only if that edge was an enabled, non-reset edge
    task automatic step();
        logic e;
        e = en & rst_n;
        @(posedge clk);
        #1;
        if (out_valid && e) begin
            q_res.push_back(result);
            q_tag.push_back(out_tag);
        end
    endtask

    task automatic run_op(input string name, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input logic [3:0] t, input bit chk_lat);
        int n;
        q_res.delete();
        q_tag.delete();
        op = o; dataa = a; datab = b; in_tag = t; in_valid = 1'b1; en = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (q_res.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check({name, "_count"}, q_res.size(), 1);
        if (q_res.size() > 0) begin
            check(name, q_res[0], exp);
            check({name, "_tag"}, {28'b0, q_tag[0]}, {28'b0, t});
            if (chk_lat) begin
                check({name, "_latency"}, n, 5);
                step();
                check({name, "_onecycle"}, {31'b0, out_valid}, 32'd0);
            end
        end
    endtask

    initial begin
        // reset state
        repeat (2) step();
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_tag", {28'b0, out_tag}, 32'd0);
        rst_n = 1'b1;
        step();

        // directed single operations
        run_op("add_1_2",      1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'd3,  1'b1);
        run_op("sub_1_1",      1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'd1,  1'b0);
        run_op("neg0_neg0",    1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'd2,  1'b0);
        run_op("tie_even",     1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'd4,  1'b0);
        run_op("round_up",     1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 4'd5,  1'b0);
        run_op("inf_m_inf",    1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'd6,  1'b0);
        run_op("overflow",     1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'd7,  1'b0);
        run_op("denorm_zero",  1'b0, 32'h00400000, 32'h00000000, 32'h00000000, 4'd8,  1'b0);
        run_op("sub_3_1",      1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 4'd9,  1'b0);
        run_op("sub_1_2",      1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'd10, 1'b0);
        run_op("nan_in",       1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'd11, 1'b0);
        run_op("one_m_neginf", 1'b1, 32'h3F800000, 32'hFF800000, 32'h7F800000, 4'd12, 1'b0);
        run_op("underflow",    1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 4'd13, 1'b0);
        run_op("neg0_pos0",    1'b0, 32'h80000000, 32'h00000000, 32'h00000000, 4'd14, 1'b1);

        // back-to-back stream with a three-cycle stall in the middle
        q_res.delete();
        q_tag.delete();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                en = 1'b0;
                in_valid = 1'b1;
                dataa = 32'h42C80000;
                datab = 32'h42C80000;
                in_tag = 4'hF;
                repeat (3) step();
                en = 1'b1;
            end
            op = 1'b0;
            dataa = st_a[i];
            datab = 32'h3F800000;
            in_tag = 4'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        check("stream_count", q_res.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_res.size()) begin
                check($sformatf("stream_res%0d", i), q_res[i], st_exp[i]);
                check($sformatf("stream_tag%0d", i), {28'b0, q_tag[i]}, i);
            end
        end

        // reset with three operations in flight
        q_res.delete();
        q_tag.delete();
        for (int i = 0; i < 3; i++) begin
            op = 1'b0;
            dataa = 32'h3F800000;
            datab = 32'h40000000;
            in_tag = 4'(i + 1);
            in_valid = 1'b1;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_result", result, 32'h0);
        repeat (3) step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (8) step();
        check("postreset_quiet", q_res.size(), 0);
        run_op("postreset_op", 1'b0, 32'h40400000, 32'h3F800000, 32'h40800000, 4'd9, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
